// File: rtl/serial_adder.sv
// Bit-serial LSB-first adder: SUM = A + B + CIN over WIDTH clock cycles.
// Define SERIAL_ADDER_OVF_EN to add the signed-overflow output OVF.
module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             START,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             CIN,
   output logic             BUSY,
   output logic             DONE,
   output logic [WIDTH-1:0] SUM,
`ifdef SERIAL_ADDER_OVF_EN
   output logic             OVF,
`endif
   output logic             COUT
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

   state_t           state;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic             carry;
   logic [CW-1:0]    cnt;
   logic             s_bit;
   logic             c_next;

   assign s_bit  = a_sh[0] ^ b_sh[0] ^ carry;
   assign c_next = (a_sh[0] & b_sh[0]) | (carry & (a_sh[0] ^ b_sh[0]));

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state <= S_IDLE;
         a_sh  <= '0;
         b_sh  <= '0;
         carry <= 1'b0;
         cnt   <= '0;
         BUSY  <= 1'b0;
         DONE  <= 1'b0;
         SUM   <= '0;
         COUT  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
         OVF   <= 1'b0;
`endif
      end else begin
         case (state)
            // DONE behaves like IDLE for acceptance, giving back-to-back ops
            S_IDLE, S_DONE: begin
               DONE <= 1'b0;
               if (START) begin
                  a_sh  <= A;
                  b_sh  <= B;
                  carry <= CIN;
                  cnt   <= '0;
                  BUSY  <= 1'b1;
                  state <= S_SHIFT;
               end else begin
                  state <= S_IDLE;
               end
            end
            S_SHIFT: begin
               SUM   <= {s_bit, SUM[WIDTH-1:1]};
               a_sh  <= a_sh >> 1;
               b_sh  <= b_sh >> 1;
               carry <= c_next;
               cnt   <= cnt + 1'b1;
               if (cnt == LAST) begin
                  COUT  <= c_next;
`ifdef SERIAL_ADDER_OVF_EN
                  // carry holds the carry into the MSB at this edge
                  OVF   <= carry ^ c_next;
`endif
                  BUSY  <= 1'b0;
                  DONE  <= 1'b1;
                  state <= S_DONE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
